// File: rtl/cpu_run_controller.sv
// Run/step/halt gating of the divided-clock tick into a one-cycle pipeline enable,
// with debounced board buttons and an executed-cycle counter, all on clk.
//
// state  | meaning
// IDLE   | paused, ticks are dropped
// RUN    | every tick issues cpu_en
// STEP   | next tick issues one cpu_en, then back to IDLE
// HALTED | processor halted, only reset leaves

module cpu_run_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_d <= level;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Only the rising edge of the debounced level counts as a press.
    assign press = level & ~level_d;
endmodule

module cpu_run_controller #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_clock,
    input  logic             btn_run,
    input  logic             btn_step,
    input  logic             cpu_halt,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_count
);
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        STEP   = 2'b10,
        HALTED = 2'b11
    } state_t;

    state_t state_q;
    logic   div_s1;
    logic   div_s2;
    logic   div_p;
    logic   tick;
    logic   run_press;
    logic   step_press;
    logic   en_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_s1 <= 1'b0;
            div_s2 <= 1'b0;
            div_p  <= 1'b0;
        end else begin
            div_s1 <= div_clock;
            div_s2 <= div_s1;
            div_p  <= div_s2;
        end
    end

    assign tick = div_s2 & ~div_p;

    cpu_run_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_run (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_run),
        .press (run_press)
    );

    cpu_run_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_step (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_step),
        .press (step_press)
    );

    assign en_next = tick & ~cpu_halt & ((state_q == RUN) | (state_q == STEP));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cpu_en      <= 1'b0;
            cycle_count <= '0;
        end else begin
            cpu_en      <= en_next;
            cycle_count <= cycle_count + {{(CNT_W-1){1'b0}}, en_next};
            case (state_q)
                IDLE: begin
                    if (run_press)       state_q <= RUN;
                    else if (step_press) state_q <= STEP;
                end
                RUN: begin
                    if (cpu_halt)       state_q <= HALTED;
                    else if (run_press) state_q <= IDLE;
                end
                STEP: begin
                    // The enabling tick and the return to IDLE share one edge.
                    if (cpu_halt)  state_q <= HALTED;
                    else if (tick) state_q <= IDLE;
                end
                HALTED:  state_q <= HALTED;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign state = state_q;
endmodule

// File: tb/tb_cpu_run_controller.sv
// Randomized scenario bench for cpu_run_controller with a pulse monitor and an
// expected state / pulse-count model kept at the scenario level.
module tb_cpu_run_controller;
    localparam int DEB = 4;
    localparam int CW  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          div_clock = 1'b0;
    logic          btn_run = 1'b0;
    logic          btn_step = 1'b0;
    logic          cpu_halt = 1'b0;
    logic          cpu_en;
    logic [1:0]    state;
    logic [CW-1:0] cycle_count;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int last_rise = -100;
    int pulse_total = 0;
    int exp_count = 0;
    logic [1:0] exp_state = 2'b00;
    logic prev_en = 1'b0;

    cpu_run_controller #(.DEBOUNCE_CYCLES(DEB), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .div_clock   (div_clock),
        .btn_run     (btn_run),
        .btn_step    (btn_step),
        .cpu_halt    (cpu_halt),
        .cpu_en      (cpu_en),
        .state       (state),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every enable pulse must land 3 edges after the latest div_clock rise and be one cycle wide.
    always @(negedge clk) begin
        if (rst_n && cpu_en) begin
            pulse_total++;
            compared++;
            if (cyc != last_rise + 3) begin
                mismatched++;
                $display("FAIL en_latency: pulse at cycle %0d, required cycle %0d", cyc, last_rise + 3);
            end
            compared++;
            if (prev_en) begin
                mismatched++;
                $display("FAIL en_width: cpu_en high on consecutive cycles at cycle %0d, required 1-cycle pulse", cyc);
            end
        end
        prev_en = rst_n & cpu_en;
    end

    task automatic step_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic div_period(input int hi, input int lo);
        div_clock = 1'b1;
        last_rise = cyc;
        step_clk(hi);
        div_clock = 1'b0;
        step_clk(lo);
    endtask

    task automatic press(input logic r, input logic s);
        btn_run  = r;
        btn_step = s;
        step_clk(10);
        btn_run  = 1'b0;
        btn_step = 1'b0;
        step_clk(10);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        div_clock = 1'b0; btn_run = 1'b0; btn_step = 1'b0; cpu_halt = 1'b0;
        step_clk(3);
        rst_n = 1'b1;
        step_clk(2);
        exp_count = 0;
        exp_state = 2'b00;
    endtask

    task automatic test_reset();
        #2;
        compared++;
        if (cpu_en !== 1'b0) begin mismatched++; $display("FAIL reset_en: got %b, want 0", cpu_en); end
        compared++;
        if (state !== exp_state) begin mismatched++; $display("FAIL reset_state: got %b, want %b", state, exp_state); end
        compared++;
        if (cycle_count !== CW'(exp_count)) begin mismatched++; $display("FAIL reset_count: got %0d, want %0d", cycle_count, exp_count); end
        do_reset();
        compared++;
        if (state !== exp_state) begin mismatched++; $display("FAIL post_reset_state: got %b, want %b", state, exp_state); end
        compared++;
        if (cycle_count !== CW'(exp_count)) begin mismatched++; $display("FAIL post_reset_count: got %0d, want %0d", cycle_count, exp_count); end
    endtask

    task automatic test_run_pause();
        int base;
        int m;
        press(1'b1, 1'b0);
        exp_state = 2'b01;
        compared++;
        if (state !== exp_state) begin mismatched++; $display("FAIL run_enter: state %b, want %b", state, exp_state); end
        base = pulse_total;
        for (int i = 0; i < 5; i++) div_period(5, 5);
        step_clk(3);
        exp_count = (exp_count + 5) % 256;
        compared++;
        if (pulse_total - base != 5) begin mismatched++; $display("FAIL run_pulses: got %0d, want 5", pulse_total - base); end
        compared++;
        if (cycle_count !== CW'(exp_count)) begin mismatched++; $display("FAIL run_count: got %0d, want %0d", cycle_count, exp_count); end
        m = $urandom_range(1, 5);
        base = pulse_total;
        for (int i = 0; i < m; i++) div_period($urandom_range(2, 6), $urandom_range(2, 6));
        step_clk(3);
        exp_count = (exp_count + m) % 256;
        compared++;
        if (pulse_total - base != m) begin mismatched++; $display("FAIL run_rand_pulses: got %0d, want %0d", pulse_total - base, m); end
        compared++;
        if (cycle_count !== CW'(exp_count)) begin mismatched++; $display("FAIL run_rand_count: got %0d, want %0d", cycle_count, exp_count); end
        press(1'b1, 1'b0);
        exp_state = 2'b00;
        compared++;
        if (state !== exp_state) begin mismatched++; $display("FAIL pause_state: got %b, want %b", state, exp_state); end
        base = pulse_total;
        div_period(5, 5);
        div_period(5, 5);
        step_clk(3);
        compared++;
        if (pulse_total - base != 0) begin mismatched++; $display("FAIL pause_pulses: got %0d, want 0", pulse_total - base); end
        compared++;
        if (cycle_count !== CW'(exp_count)) begin mismatched++; $display("FAIL pause_count: got %0d, want %0d", cycle_count, exp_count); end
    endtask

    task automatic test_step();
        int base;
        press(1'b0, 1'b1);
        exp_state = 2'b10;
        compared++;
        if (state !== exp_state) begin mismatched++; $display("FAIL step_enter: state %b, want %b", state, exp_state); end
        press(1'b0, 1'b1);
        compared++;
        if (state !== exp_state) begin mismatched++; $display("FAIL step_repress: state %b, want %b", state, exp_state); end
        base = pulse_total;
        div_period(5, 5);
        step_clk(3);
        exp_count = (exp_count + 1) % 256;
        exp_state = 2'b00;
        compared++;
        if (state !== exp_state) begin mismatched++; $display("FAIL step_exit: state %b, want %b", state, exp_state); end
        compared++;
        if (pulse_total - base != 1) begin mismatched++; $display("FAIL step_pulses: got %0d, want 1", pulse_total - base); end
        compared++;
        if (cycle_count !== CW'(exp_count)) begin mismatched++; $display("FAIL step_count: got %0d, want %0d", cycle_count, exp_count); end
        base = pulse_total;
        div_period(4, 4);
        div_period(4, 4);
        step_clk(3);
        compared++;
        if (pulse_total - base != 0) begin mismatched++; $display("FAIL step_idle_pulses: got %0d, want 0", pulse_total - base); end
    endtask

    // Run press and tick reach the FSM on the same edge: pulse still issued, state to IDLE.
    task automatic test_run_tick_collision();
        int base;
        press(1'b1, 1'b0);
        exp_state = 2'b01;
        compared++;
        if (state !== exp_state) begin mismatched++; $display("FAIL coll_enter: state %b, want %b", state, exp_state); end
        base = pulse_total;
        for (int i = 0; i < 12; i++) begin
            btn_run   = (i < 10);
            div_clock = (i >= 4 && i < 9);
            if (i == 4) last_rise = cyc;
            step_clk(1);
        end
        btn_run = 1'b0;
        step_clk(10);
        exp_count = (exp_count + 1) % 256;
        exp_state = 2'b00;
        compared++;
        if (state !== exp_state) begin mismatched++; $display("FAIL coll_state: got %b, want %b", state, exp_state); end
        compared++;
        if (pulse_total - base != 1) begin mismatched++; $display("FAIL coll_pulses: got %0d, want 1", pulse_total - base); end
        compared++;
        if (cycle_count !== CW'(exp_count)) begin mismatched++; $display("FAIL coll_count: got %0d, want %0d", cycle_count, exp_count); end
    endtask

    task automatic test_debounce();
        int total;
        int len;
        for (int g = 0; g < 6; g++) begin
            len = $urandom_range(1, DEB - 1);
            btn_run = 1'b1;
            step_clk(len);
            btn_run = 1'b0;
            step_clk(6);
            compared++;
            if (state !== exp_state) begin mismatched++; $display("FAIL glitch_%0d_len%0d: state %b, want %b", g, len, state, exp_state); end
        end
        total = 0;
        while (total < 20) begin
            len = $urandom_range(1, DEB - 1);
            btn_run = 1'b1;
            step_clk(len);
            total += len;
            len = $urandom_range(1, DEB - 1);
            btn_run = 1'b0;
            step_clk(len);
            total += len;
        end
        btn_run = 1'b1;
        step_clk(12);
        exp_state = 2'b01;
        compared++;
        if (state !== exp_state) begin mismatched++; $display("FAIL bounce_press: state %b, want %b", state, exp_state); end
        btn_run = 1'b0;
        step_clk(10);
        compared++;
        if (state !== exp_state) begin mismatched++; $display("FAIL bounce_release: state %b, want %b", state, exp_state); end
    endtask

    task automatic test_mid_reset();
        div_clock = 1'b1;
        last_rise = cyc;
        step_clk(3);
        compared++;
        if (cpu_en !== 1'b1) begin mismatched++; $display("FAIL midrst_pre_en: got %b, want 1", cpu_en); end
        rst_n = 1'b0;
        #1;
        compared++;
        if (cpu_en !== 1'b0) begin mismatched++; $display("FAIL midrst_async_en: got %b, want 0", cpu_en); end
        div_clock = 1'b0;
        step_clk(2);
        rst_n = 1'b1;
        step_clk(2);
        exp_count = 0;
        exp_state = 2'b00;
        compared++;
        if (cycle_count !== CW'(exp_count)) begin mismatched++; $display("FAIL midrst_count: got %0d, want %0d", cycle_count, exp_count); end
        compared++;
        if (state !== exp_state) begin mismatched++; $display("FAIL midrst_state: got %b, want %b", state, exp_state); end
    endtask

    task automatic test_halt();
        int base;
        press(1'b1, 1'b0);
        exp_state = 2'b01;
        base = pulse_total;
        div_period(4, 4);
        step_clk(2);
        exp_count = (exp_count + 1) % 256;
        compared++;
        if (cycle_count !== CW'(exp_count)) begin mismatched++; $display("FAIL halt_pre_count: got %0d, want %0d", cycle_count, exp_count); end
        div_clock = 1'b1;
        last_rise = cyc;
        step_clk(2);
        cpu_halt = 1'b1;
        step_clk(1);
        cpu_halt = 1'b0;
        step_clk(2);
        div_clock = 1'b0;
        step_clk(5);
        exp_state = 2'b11;
        compared++;
        if (state !== exp_state) begin mismatched++; $display("FAIL halt_state: got %b, want %b", state, exp_state); end
        compared++;
        if (pulse_total - base != 1) begin mismatched++; $display("FAIL halt_pulses: got %0d, want 1", pulse_total - base); end
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) div_period($urandom_range(2, 5), $urandom_range(2, 5));
        step_clk(3);
        compared++;
        if (state !== exp_state) begin mismatched++; $display("FAIL halt_sticky: got %b, want %b", state, exp_state); end
        compared++;
        if (cycle_count !== CW'(exp_count)) begin mismatched++; $display("FAIL halt_count: got %0d, want %0d", cycle_count, exp_count); end
        compared++;
        if (pulse_total - base != 1) begin mismatched++; $display("FAIL halt_post_pulses: got %0d, want 1", pulse_total - base); end
    endtask

    task automatic test_wrap();
        int base;
        do_reset();
        press(1'b1, 1'b0);
        base = pulse_total;
        for (int i = 0; i < 255; i++) div_period($urandom_range(2, 3), $urandom_range(2, 3));
        step_clk(3);
        exp_count = (exp_count + 255) % 256;
        compared++;
        if (cycle_count !== CW'(exp_count)) begin mismatched++; $display("FAIL wrap_preload: got %0d, want %0d", cycle_count, exp_count); end
        compared++;
        if (pulse_total - base != 255) begin mismatched++; $display("FAIL wrap_pulses: got %0d, want 255", pulse_total - base); end
        div_period(2, 2);
        step_clk(3);
        exp_count = (exp_count + 1) % 256;
        compared++;
        if (cycle_count !== CW'(exp_count)) begin mismatched++; $display("FAIL wrap_zero: got %0d, want %0d", cycle_count, exp_count); end
    endtask

    task automatic test_priority();
        do_reset();
        press(1'b1, 1'b1);
        exp_state = 2'b01;
        compared++;
        if (state !== exp_state) begin mismatched++; $display("FAIL priority_state: got %b, want %b", state, exp_state); end
    endtask

    initial begin
        test_reset();
        test_run_pause();
        test_step();
        test_run_tick_collision();
        test_debounce();
        test_mid_reset();
        test_halt();
        test_wrap();
        test_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
